// File: rtl/se_pal_4bits.sv
// Serial-to-parallel receiver for the 4-bit MSB-first link: sync marks the MSB, and each completed word lands on out/valid.
// Optional hold/acknowledge mode with overrun flag is enabled by defining SE_PAL_HOLD_EN.
module se_pal_4bits (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       sync,
  input  logic       ack,
  output logic [3:0] out,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] sh_q, sh_d;
  logic [3:0] out_q, out_d;
  logic       valid_q, valid_d;
  logic       frame_err_q, frame_err_d;
  logic       complete;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    out_d       = out_q;
    frame_err_d = 1'b0;
    complete    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync) begin
          sh_d    = {sh_q[1:0], in};
          cnt_d   = 2'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A sync mid-word restarts framing; the stale bits shift out naturally.
        if (sync) begin
          frame_err_d = 1'b1;
          sh_d        = {sh_q[1:0], in};
          cnt_d       = 2'd1;
        end else if (cnt_q == 2'd3) begin
          out_d    = {sh_q, in};
          complete = 1'b1;
          cnt_d    = 2'd0;
          state_d  = IDLE;
        end else begin
          sh_d  = {sh_q[1:0], in};
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

`ifdef SE_PAL_HOLD_EN
  logic overrun_q, overrun_d;

  always_comb begin
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (complete) begin
      valid_d = 1'b1;
    end else if (ack) begin
      valid_d = 1'b0;
    end
    // Ack wins over a simultaneous overwrite: the consumer took the old word.
    if (ack) begin
      overrun_d = 1'b0;
    end else if (complete && valid_q) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  logic unused_ack;

  always_comb begin
    valid_d = complete;
  end

  assign unused_ack = ack;
  assign overrun    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      sh_q        <= 3'd0;
      out_q       <= 4'd0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out       = out_q;
  assign valid     = valid_q;
  assign busy      = (state_q == SHIFT);
  assign frame_err = frame_err_q;

endmodule

// File: doc/se_pal_4bits.md
# se_pal_4bits

Serial-to-parallel receiver for the 4-bit MSB-first serial link produced by the team's parallel-to-serial shifter. It samples one bit per clock on `in`, and a `sync` strobe marks each word's first bit (MSB). It assembles 4-bit words into a parallel output register and flags them with `valid`. It also detects framing errors (a restart mid-word) and, when configured, holds each word until acknowledged and flags overruns.

## Interface
- No parameters; word width fixed at 4.
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-low; `reset`=0 at a rising edge clears all state.
- `in` input 1: serial data bit, sampled every rising edge.
- `sync` input 1: when 1, the `in` bit sampled at the same edge is bit 3 (MSB) of a new word.
- `ack` input 1: consumer acknowledge; used only with `SE_PAL_HOLD_EN`.
- `out` output 4: last completed word; reset 4'b0000.
- `valid` output 1: word available on `out`; reset 0.
- `busy` output 1: 1 while a word is partially received (state SHIFT); reset 0.
- `frame_err` output 1: one-cycle pulse on aborted word; reset 0.
- `overrun` output 1: sticky overwrite flag; reset 0.

## Operation
- Internal state: FSM {IDLE, SHIFT}, 2-bit bit counter `cnt`, 3-bit shift register `sh`.
- IDLE:
  - `sync`=1: `sh`←{`sh`[1:0],`in`}, `cnt`←1, go to SHIFT.
  - `sync`=0: `in` is ignored.
- SHIFT, `sync`=0, `cnt`<3: shift `in` into `sh`, `cnt`←`cnt`+1.
- SHIFT, `sync`=0, `cnt`=3: `out`←{`sh`,`in`}, word complete, `cnt`←0, go to IDLE.
- SHIFT, `sync`=1 at any `cnt`:
  - Discard the partial word and pulse `frame_err` for one cycle.
  - Treat `in` as the MSB of a new word: `cnt`←1, stay in SHIFT.
  - `out` and `valid` are unchanged.
- Bit order: first sampled bit goes to `out`[3], last to `out`[0].
- Back-to-back words: `sync` every 4th edge is legal. The completing edge returns to IDLE, so a `sync` on the following edge starts cleanly with no `frame_err`.
- Reset mid-word: the partial word is lost. FSM→IDLE, `cnt`←0, `sh`←0, and all outputs go to their reset values.
- Reset has priority over `sync`, `ack` and completion at the same edge.

## Timing
- `sync` edge = E0. Bits are sampled at E0, E1, E2, E3.
- `out` and `valid` update at E3, visible immediately after it. Latency is 4 edges from the `sync` edge inclusive.
- `busy` is 1 after E0 through E2 and 0 after E3.
- `frame_err` is high for exactly the cycle following the offending `sync` edge.
- The serial-side sustained rate is one word per 4 clocks; the receiver has no stall input.

## Configuration
- Macro `SE_PAL_HOLD_EN`.
- Defined:
  - `valid` rises at completion and stays 1 until an edge with `ack`=1 and no completion, which clears it.
  - Completion while `valid`=1 and `ack`=0: `out` is overwritten with the new word, `valid` stays 1, `overrun`←1.
  - Completion with `ack`=1 at the same edge: new word loads, `valid` stays 1, no overrun.
  - `overrun` clears on reset or on any edge with `ack`=1 (ack with simultaneous overwrite leaves it 0).
- Undefined:
  - `valid` is a single-cycle pulse after each completion edge.
  - `ack` is ignored and `overrun` is tied to 0.
  - `out` holds the last word until the next completion.

## Test plan
- Reset then word: `reset`=0 for one edge, then `sync`=1 with bits 1,0,1,1 on consecutive edges → `out`=4'b1011, `valid`=1 after the 4th edge, `busy`=0 after it, `frame_err` never set.
- Framing abort: send 1,0 after `sync`, then `sync`=1 with 0,1,0,1 → `frame_err` one-cycle pulse after the 2nd `sync` edge, `out` keeps its prior value until 4'b0101 completes, `valid` after the 4th bit of the new word.
- Back-to-back: 1011 then `sync` on the next edge with 1001 → two completions 4 clocks apart, `out`=4'b1011 then 4'b1001, no `frame_err`.
- Reset mid-word: `sync` with 1,1 then `reset`=0 at the 3rd edge → all outputs 0, `busy`=0, no word delivered; next clean frame 0110 → `out`=4'b0110.
- `SE_PAL_HOLD_EN` overrun: two words 1011, 0101 with `ack`=0 → `valid` stays 1, `out`=4'b0101, `overrun`=1; `ack`=1 for one edge → `valid`=0, `overrun`=0.
- `SE_PAL_HOLD_EN` ack on completion edge: `ack`=1 at the completion edge of 1001 while `valid`=1 → `out`=4'b1001, `valid`=1, `overrun`=0.
